// File: rtl/parity_serdes.sv
// Clocked serial parity unit: the TX path serialises a word LSB-first and appends a parity bit.
// The RX path rebuilds a word from a serial stream and flags parity failures.
module parity_serdes #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             tx_last,
  input  logic             rx_bit,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: a word moves on a rising edge where in_valid and in_ready are both high,
  // and in_data is sampled only on that edge. The serial side has no ready signal:
  // TX never stalls once a frame starts, and RX consumes every bit marked by rx_valid.

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} tx_state_t;

  tx_state_t        tx_state, tx_state_next;
  logic [WIDTH-1:0] tx_shreg, tx_shreg_next;
  logic             tx_acc, tx_acc_next;
  logic [CW-1:0]    tx_cnt, tx_cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_shreg <= '0;
      tx_acc   <= 1'b0;
      tx_cnt   <= '0;
    end else begin
      tx_state <= tx_state_next;
      tx_shreg <= tx_shreg_next;
      tx_acc   <= tx_acc_next;
      tx_cnt   <= tx_cnt_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_shreg_next = tx_shreg;
    tx_acc_next   = tx_acc;
    tx_cnt_next   = tx_cnt;
    in_ready      = 1'b0;
    tx_valid      = 1'b0;
    tx_last       = 1'b0;
    tx_bit        = 1'b0;
    unique case (tx_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tx_shreg_next = in_data;
          tx_acc_next   = ODD;
          tx_cnt_next   = '0;
          tx_state_next = SHIFT;
        end
      end
      SHIFT: begin
        tx_valid      = 1'b1;
        tx_bit        = tx_shreg[0];
        tx_acc_next   = tx_acc ^ tx_shreg[0];
        tx_shreg_next = tx_shreg >> 1;
        tx_cnt_next   = tx_cnt + 1'b1;
        if (tx_cnt == CW'(WIDTH - 1)) tx_state_next = PAR;
      end
      PAR: begin
        // Accumulator now holds ^in_data ^ ODD.
        tx_valid      = 1'b1;
        tx_last       = 1'b1;
        tx_bit        = tx_acc;
        tx_state_next = IDLE;
      end
      default: tx_state_next = IDLE;
    endcase
  end

  logic [CW-1:0]    rx_cnt;
  logic [WIDTH-1:0] rx_word;
  logic             rx_acc;

  // rx_word is a separate assembly buffer so out_data holds steady while the next frame arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt     <= '0;
      rx_word    <= '0;
      rx_acc     <= ODD;
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (rx_valid) begin
        if (rx_cnt == CW'(WIDTH)) begin
          out_data   <= rx_word;
          parity_err <= rx_acc ^ rx_bit;
          out_valid  <= 1'b1;
          rx_cnt     <= '0;
          rx_acc     <= ODD;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (rx_cnt == CW'(i)) rx_word[i] <= rx_bit;
          end
          rx_acc <= rx_acc ^ rx_bit;
          rx_cnt <= rx_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_parity_serdes.sv
// Bench for parity_serdes: even (8-bit), odd (8-bit) and 1-bit instances with table vectors,
// hand-written corner sequences and randomized traffic checked against a parity model.
module tb_parity_serdes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: WIDTH=8, even parity; RX either loops back from TX or is driven by the bench.
  logic [7:0] a_in_data;
  logic       a_in_valid, a_in_ready, a_tx_bit, a_tx_valid, a_tx_last;
  logic       a_loop, a_rx_drv, a_rx_vdrv, a_rx_bit, a_rx_valid;
  logic [7:0] a_out_data;
  logic       a_out_valid, a_perr;
  assign a_rx_bit   = a_loop ? a_tx_bit   : a_rx_drv;
  assign a_rx_valid = a_loop ? a_tx_valid : a_rx_vdrv;

  // Instance B: WIDTH=8, odd parity; same TX stimulus as A, RX looped back.
  logic       b_in_ready, b_tx_bit, b_tx_valid, b_tx_last;
  logic [7:0] b_out_data;
  logic       b_out_valid, b_perr;

  // Instance C: WIDTH=1, even parity, RX looped back.
  logic [0:0] c_in_data, c_out_data;
  logic       c_in_valid, c_in_ready, c_tx_bit, c_tx_valid, c_tx_last, c_out_valid, c_perr;

  parity_serdes #(.WIDTH(8), .ODD(1'b0)) u_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .tx_bit(a_tx_bit), .tx_valid(a_tx_valid), .tx_last(a_tx_last), .rx_bit(a_rx_bit),
    .rx_valid(a_rx_valid), .out_data(a_out_data), .out_valid(a_out_valid), .parity_err(a_perr));

  parity_serdes #(.WIDTH(8), .ODD(1'b1)) u_b (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(b_in_ready),
    .tx_bit(b_tx_bit), .tx_valid(b_tx_valid), .tx_last(b_tx_last), .rx_bit(b_tx_bit),
    .rx_valid(b_tx_valid), .out_data(b_out_data), .out_valid(b_out_valid), .parity_err(b_perr));

  parity_serdes #(.WIDTH(1), .ODD(1'b0)) u_c (
    .clk(clk), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .tx_bit(c_tx_bit), .tx_valid(c_tx_valid), .tx_last(c_tx_last), .rx_bit(c_tx_bit),
    .rx_valid(c_tx_valid), .out_data(c_out_data), .out_valid(c_out_valid), .parity_err(c_perr));

  logic [7:0] a_txq[$];
  logic [8:0] a_rxq[$];
  logic [8:0] b_rxq[$];

  typedef struct {
    logic [7:0] w;
    logic       par_even;
    logic       par_odd;
  } vec_t;
  vec_t tbl[8];

  function automatic logic ref_par(input logic [7:0] w);
    return ($countones(w) % 2) == 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer a word with in_valid held until accepted; returns on the negedge after acceptance.
  task automatic offer_a(input logic [7:0] w);
    int t;
    t = 0;
    a_in_data  = w;
    a_in_valid = 1'b1;
    while (!a_in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("offer_wait", {31'd0, (t < 40)}, 1);
    a_txq.push_back(w);
    b_rxq.push_back({1'b0, w});
    if (a_loop) a_rxq.push_back({1'b0, w});
    @(negedge clk);
  endtask

  task automatic send_ab(input vec_t v);
    logic [8:0] fa, fb, la, lb;
    int nv, lo;
    fa = '0; fb = '0; la = '0; lb = '0; nv = 0; lo = 0;
    offer_a(v.w);
    a_in_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      fa[k] = a_tx_bit;
      fb[k] = b_tx_bit;
      la[k] = a_tx_last;
      lb[k] = b_tx_last;
      if (!a_tx_valid || !b_tx_valid) nv++;
      if (!a_in_ready) lo++;
      @(negedge clk);
    end
    check("tbl_even_frame", fa, {v.par_even, v.w});
    check("tbl_odd_frame", fb, {v.par_odd, v.w});
    check("tbl_last_a", la, 9'h100);
    check("tbl_last_b", lb, 9'h100);
    check("tbl_valid_gaps", nv, 0);
    check("tbl_ready_low", lo, 9);
    check("tbl_ready_back", a_in_ready, 1);
  endtask

  // Drive one RX frame on A; returns on the negedge after the parity bit.
  task automatic send_rx(input logic [7:0] w, input logic flip, input int gmin, input int gmax);
    logic [8:0] fr;
    fr = {ref_par(w) ^ flip, w};
    a_rxq.push_back({flip, w});
    for (int k = 0; k < 9; k++) begin
      a_rx_drv  = fr[k];
      a_rx_vdrv = 1'b1;
      @(negedge clk);
      a_rx_vdrv = 1'b0;
      if (k < 8) repeat ($urandom_range(gmax, gmin)) @(negedge clk);
    end
  endtask

  // A: serial TX frames against the parity model.
  initial begin : a_tx_mon
    logic [8:0] fr;
    logic [7:0] w;
    int n;
    n = 0;
    fr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        n = 0;
        a_txq.delete();
      end else if (a_tx_valid) begin
        if (n < 9) fr[n] = a_tx_bit;
        if (a_tx_last) begin
          check("a_tx_len", n, 8);
          if (a_txq.size() == 0) check("a_tx_pending", a_txq.size(), 1);
          else begin
            w = a_txq.pop_front();
            check("a_tx_frame", fr, {ref_par(w), w});
          end
          n = 0;
        end else n++;
      end else if (n != 0) begin
        check("a_tx_gap", n, 0);
        n = 0;
      end
    end
  end

  // A and B: received words and parity flags.
  initial begin : rx_mon
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        a_rxq.delete();
        b_rxq.delete();
      end else begin
        if (a_out_valid) begin
          if (a_rxq.size() == 0) check("a_rx_pending", a_rxq.size(), 1);
          else begin
            e = a_rxq.pop_front();
            check("a_rx_frame", {a_perr, a_out_data}, e);
          end
        end
        if (b_out_valid) begin
          if (b_rxq.size() == 0) check("b_rx_pending", b_rxq.size(), 1);
          else begin
            e = b_rxq.pop_front();
            check("b_rx_frame", {b_perr, b_out_data}, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset = 1'b1;
    a_in_data = '0; a_in_valid = 1'b0; a_loop = 1'b1; a_rx_drv = 1'b0; a_rx_vdrv = 1'b0;
    c_in_data = '0; c_in_valid = 1'b0;
    tbl[0] = '{8'hA5, 1'b0, 1'b1};
    tbl[1] = '{8'h07, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b1};
    tbl[3] = '{8'hFF, 1'b0, 1'b1};
    tbl[4] = '{8'h3C, 1'b0, 1'b1};
    tbl[5] = '{8'h01, 1'b1, 1'b0};
    tbl[6] = '{8'h80, 1'b1, 1'b0};
    tbl[7] = '{8'h6E, 1'b1, 1'b0};
    repeat (2) @(negedge clk);

    check("rst_in_ready", a_in_ready, 1);
    check("rst_tx", {a_tx_bit, a_tx_valid, a_tx_last}, 0);
    check("rst_out", {a_out_valid, a_perr, a_out_data}, 0);
    check("rst_c_ready", c_in_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) send_ab(tbl[i]);
    repeat (3) @(negedge clk);

    // Three loopback words with in_valid held high: completions 10 cycles apart.
    fork
      begin
        offer_a(8'h00);
        offer_a(8'hFF);
        offer_a(8'h3C);
        a_in_valid = 1'b0;
      end
      begin : lb3_wait
        int t, n;
        int ts[3];
        t = 0; n = 0;
        while (n < 3 && t < 100) begin
          if (a_out_valid) begin
            ts[n] = cyc;
            n++;
          end
          @(negedge clk);
          t++;
        end
        check("lb3_count", n, 3);
        if (n == 3) begin
          check("lb3_gap1", ts[1] - ts[0], 10);
          check("lb3_gap2", ts[2] - ts[1], 10);
        end
      end
    join
    repeat (3) @(negedge clk);

    for (int i = 0; i < 12; i++) offer_a(8'($urandom_range(255, 0)));
    a_in_valid = 1'b0;
    repeat (15) @(negedge clk);

    // Bench-driven RX: 5A with flipped parity and 2-cycle gaps.
    a_loop = 1'b0;
    send_rx(8'h5A, 1'b1, 2, 2);
    check("rx5a_valid", a_out_valid, 1);
    check("rx5a_data", a_out_data, 8'h5A);
    check("rx5a_err", a_perr, 1);
    @(negedge clk);
    check("rx5a_pulse", a_out_valid, 0);

    // Reset in the 4th SHIFT cycle with an RX frame half received.
    a_in_data = 8'h96; a_in_valid = 1'b1; a_rx_vdrv = 1'b1; a_rx_drv = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      a_rx_drv = k[0];
    end
    check("pre_rst_busy", {a_tx_valid, a_in_ready}, 2'b10);
    check("pre_rst_hold", {a_perr, a_out_data}, {1'b1, 8'h5A});
    reset = 1'b1;
    #1;
    check("mid_rst_ready", a_in_ready, 1);
    check("mid_rst_tx", {a_tx_bit, a_tx_valid, a_tx_last}, 0);
    check("mid_rst_out", {a_out_valid, a_perr, a_out_data}, 0);
    a_rx_vdrv = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_rx(8'h81, 1'b0, 0, 0);
    check("post_rst_frame", {a_out_valid, a_perr, a_out_data}, {2'b10, 8'h81});
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      send_rx(8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)), 0, 3);
    repeat (3) @(negedge clk);

    // WIDTH=1 frames: data 1 -> bits 1,1; data 0 -> bits 0,0.
    for (int d = 1; d >= 0; d--) begin
      c_in_data  = 1'(d);
      c_in_valid = 1'b1;
      @(negedge clk);
      c_in_valid = 1'b0;
      check("c_data_bit", {c_tx_valid, c_tx_last, c_tx_bit}, {2'b10, 1'(d)});
      @(negedge clk);
      check("c_par_bit", {c_tx_valid, c_tx_last, c_tx_bit}, {2'b11, 1'(d)});
      @(negedge clk);
      check("c_rx_out", {c_out_valid, c_perr, c_out_data}, {2'b10, 1'(d)});
      check("c_ready", c_in_ready, 1);
    end

    repeat (5) @(negedge clk);
    check("a_txq_empty", a_txq.size(), 0);
    check("a_rxq_empty", a_rxq.size(), 0);
    check("b_rxq_empty", b_rxq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
